pipe_stall_ctrl: RTL
====================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central stall sequencer for the 5-stage pipeline. Collects stall requests from IF, ID, EX
//  (multi-cycle ops) and MEM (data-bus wait). Drives stall[5:0] into pc_reg and all inter-stage
//  registers. Tracks multi-cycle EX ops and MEM bus waits with FSMs; aborts a hung bus access
//  after a timeout.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles in MEM_WAIT before forced release (>=2)
//  TO_W         5   width of timeout counter; must hold MEM_TIMEOUT
// PORTS
//  clk            in   1   pipeline clock
//  rst            in   1   synchronous reset, active-high
//  stallreq_if    in   1   IF waiting on instruction fetch
//  stallreq_id    in   1   ID load-use hazard
//  ex_multi_start in   1   EX issuing multi-cycle op this cycle
//  ex_multi_done  in   1   multi-cycle unit result valid this cycle
//  mem_bus_req    in   1   MEM stage holds load/store needing the bus
//  mem_bus_ack    in   1   data bus completes access this cycle
//  stall          out  6   [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = hold
//  mem_timeout    out  1   one-cycle pulse: bus access aborted
//  ex_busy        out  1   EX FSM in EX_BUSY
// BEHAVIOUR
//  - Single clock domain. All state updates on posedge clk. rst has priority over every input.
//  - Reset: ex FSM=EX_IDLE, mem FSM=M_IDLE, to_cnt=0, mem_timeout=0, ex_busy=0.
//    With all requests low, stall=6'b000000.
//  - stall is combinational from current FSM state and current requests. Same-cycle response,
//    zero latency. The deepest requesting stage wins; result is a prefix mask:
//      MEM wait -> 6'b011111; EX wait -> 6'b001111; ID -> 6'b000111; IF -> 6'b000011; none -> 0.
//  - stall[5] is never asserted. The stage just below the stall boundary advances.
//    The downstream pipe register inserts the bubble.
//  - EX FSM (EX_IDLE, EX_BUSY):
//      EX_IDLE: ex_multi_start=1 -> ex wait asserted this cycle; next state EX_BUSY.
//        If ex_multi_done is also 1, the op is single-cycle: no EX wait, stay EX_IDLE.
//      EX_BUSY: ex wait asserted while ex_multi_done=0.
//        On ex_multi_done=1: no ex wait this cycle; next state EX_IDLE.
//      ex_multi_start is ignored in EX_BUSY.
//  - MEM FSM (M_IDLE, M_WAIT):
//      M_IDLE: mem_bus_req=1 and mem_bus_ack=0 -> mem wait this cycle; to_cnt<=1; next M_WAIT.
//        req=1 and ack=1 -> no stall.
//      M_WAIT: mem wait while ack=0; to_cnt increments each cycle.
//        ack=1 -> no mem wait this cycle; next M_IDLE; to_cnt<=0.
//        ack=0 and to_cnt==MEM_TIMEOUT-1 -> no mem wait this cycle; mem_timeout=1 (registered,
//          visible the following cycle for exactly 1 cycle); next M_IDLE; to_cnt<=0.
//        mem_bus_req dropping to 0 in M_WAIT -> abort silently; next M_IDLE; no timeout pulse.
//  - EX and MEM FSMs are independent. With both waiting, the MEM mask (011111) applies.
//    An EX op stays frozen in EX_BUSY and keeps waiting for done.
//  - In the cycle ack=1 while EX_BUSY, stall=6'b001111: MEM advances, EX holds.
//  - rst asserted mid-operation: both FSMs return to idle on the next edge. Any pending
//    timeout is dropped and mem_timeout=0.
// CONFIGURATION
//  STALL_CTRL_PERF_EN defined: adds outputs perf_stall_cycles[31:0] and perf_mem_wait[31:0].
//    Counters reset to 0. perf_stall_cycles increments each cycle stall!=0.
//    perf_mem_wait increments each cycle the MEM mask applies. Both wrap at 2^32.
//  Not defined: ports and counters absent. All other behaviour identical.
// TESTING
//  1. rst=1 for 2 cycles, all inputs 0 -> stall=000000, mem_timeout=0, ex_busy=0.
//  2. stallreq_id=1 for 1 cycle -> stall=000111 that cycle; then 000000.
//  3. ex_multi_start=1 at T, ex_multi_done=1 at T+4 -> stall=001111 for T..T+3;
//     000000 at T+4; ex_busy=1 for T+1..T+4.
//  4. mem_bus_req held, ack never, MEM_TIMEOUT=16 -> stall=011111 for 15 cycles;
//     released on the 16th; mem_timeout=1 on the next cycle only.
//  5. EX_BUSY plus mem wait, ack at T+2, done at T+5 -> 011111 at T..T+1; 001111 at T+2..T+4;
//     000000 at T+5.
//  6. rst pulsed during M_WAIT with to_cnt=7 -> next cycle stall=000000, no mem_timeout pulse.
//     With STALL_CTRL_PERF_EN: counters read 0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall sequencer with EX multi-cycle and MEM bus-wait FSMs
// Optional perf counters enabled by defining STALL_CTRL_PERF_EN.
module pipe_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stallreq_if,
  input  logic       stallreq_id,
  input  logic       ex_multi_start,
  input  logic       ex_multi_done,
  input  logic       mem_bus_req,
  input  logic       mem_bus_ack,
  output logic [5:0] stall,
  output logic       mem_timeout,
  output logic       ex_busy
`ifdef STALL_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_mem_wait
`endif
);

  typedef enum logic {EX_IDLE, EX_BUSY} ex_state_t;
  typedef enum logic {M_IDLE, M_WAIT} mem_state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  ex_state_t       ex_state, ex_state_nxt;
  mem_state_t      mem_state, mem_state_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            timeout_nxt;
  logic            ex_wait, mem_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_state    <= EX_IDLE;
      mem_state   <= M_IDLE;
      to_cnt      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      ex_state    <= ex_state_nxt;
      mem_state   <= mem_state_nxt;
      to_cnt      <= to_cnt_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

  always_comb begin
    ex_state_nxt  = ex_state;
    mem_state_nxt = mem_state;
    to_cnt_nxt    = to_cnt;
    timeout_nxt   = 1'b0;

    case (ex_state)
      EX_IDLE: if (ex_multi_start && !ex_multi_done) ex_state_nxt = EX_BUSY;
      EX_BUSY: if (ex_multi_done) ex_state_nxt = EX_IDLE;
    endcase

    case (mem_state)
      M_IDLE: begin
        if (mem_bus_req && !mem_bus_ack) begin
          mem_state_nxt = M_WAIT;
          to_cnt_nxt    = TO_W'(1);
        end
      end
      M_WAIT: begin
        // A dropped request or a completed access leaves quietly; only a hung bus pulses.
        if (!mem_bus_req || mem_bus_ack) begin
          mem_state_nxt = M_IDLE;
          to_cnt_nxt    = '0;
        end else if (to_cnt == TO_LAST) begin
          mem_state_nxt = M_IDLE;
          to_cnt_nxt    = '0;
          timeout_nxt   = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    ex_wait  = !ex_multi_done && (ex_state == EX_BUSY || ex_multi_start);
    mem_wait = mem_bus_req && !mem_bus_ack && (mem_state == M_IDLE || to_cnt != TO_LAST);
    ex_busy  = (ex_state == EX_BUSY);

    // Deepest requester wins; WB is never held, its input register takes the bubble.
    if (mem_wait)         stall = 6'b011111;
    else if (ex_wait)     stall = 6'b001111;
    else if (stallreq_id) stall = 6'b000111;
    else if (stallreq_if) stall = 6'b000011;
    else                  stall = 6'b000000;
  end

`ifdef STALL_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_mem_wait     <= '0;
    end else begin
      if (stall != 6'b000000) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (mem_wait)           perf_mem_wait     <= perf_mem_wait + 32'd1;
    end
  end
`endif

endmodule
